// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Byte-serialising arbiter for the shared RAM/IO port: ROB stores > LB loads > IF fetches.
// Reads finish n+2 cycles after the grant cycle and writes n+1, plus IO-full stalls; a flush drops IF/LB reads.
module mem_arbiter #(
  parameter int          ADDR_W = 32,
  parameter int          DATA_W = 32,
  parameter logic [1:0]  IO_SEL = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rob_rst_in,
  input  logic              io_full_in,
  input  logic [7:0]        mem_din_in,
  output logic [7:0]        mem_dout_out,
  output logic [ADDR_W-1:0] mem_a_out,
  output logic              mem_wr_out,
  input  logic              if_en_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic [DATA_W-1:0] if_data_out,
  output logic              if_done_out,
  input  logic              lb_en_in,
  input  logic [ADDR_W-1:0] lb_addr_in,
  input  logic [2:0]        lb_width_in,
  output logic [DATA_W-1:0] lb_data_out,
  output logic              lb_done_out,
  input  logic              rob_en_in,
  input  logic [ADDR_W-1:0] rob_addr_in,
  input  logic [2:0]        rob_width_in,
  input  logic [DATA_W-1:0] rob_data_in,
  output logic              rob_done_out
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_LB, OWN_ROB} owner_t;

  state_t              r_state;
  owner_t              r_owner;
  logic [2:0]          r_len;
  logic [2:0]          r_k;
  logic [DATA_W-1:0]   r_wdat;
  logic [DATA_W-1:0]   r_buf;
  logic                r_io;
  logic [ADDR_W-1:0]   r_mem_a;
  logic [7:0]          r_mem_dout;
  logic                r_wr;
  logic [DATA_W-1:0]   r_if_data;
  logic [DATA_W-1:0]   r_lb_data;
  logic                r_if_done;
  logic                r_lb_done;
  logic                r_rob_done;

  logic                w_gnt_rob;
  logic                w_gnt_lb;
  logic                w_gnt_if;
  logic                w_stall;
  logic [2:0]          w_k_m1;
  logic [1:0]          w_cap_idx;
  logic [1:0]          w_nxt_idx;
  logic [DATA_W-1:0]   w_rdata;

  function automatic logic [2:0] f_len(input logic [2:0] w);
    case (w)
      3'b001:  return 3'd1;
      3'b010:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // A flush in IDLE only blocks the speculative requesters; committed stores still go.
  assign w_gnt_rob = rob_en_in;
  assign w_gnt_lb  = !rob_en_in && lb_en_in && !rob_rst_in;
  assign w_gnt_if  = !rob_en_in && !lb_en_in && if_en_in && !rob_rst_in;

  assign w_stall   = r_io && io_full_in;
  assign w_k_m1    = r_k - 3'd1;
  assign w_cap_idx = w_k_m1[1:0];
  assign w_nxt_idx = r_k[1:0] + 2'd1;

  // Buffer with the byte arriving this cycle merged in at its little-endian lane.
  always_comb begin
    w_rdata = r_buf;
    w_rdata[{w_cap_idx, 3'b000} +: 8] = mem_din_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_owner    <= OWN_IF;
      r_len      <= '0;
      r_k        <= '0;
      r_wdat     <= '0;
      r_buf      <= '0;
      r_io       <= 1'b0;
      r_mem_a    <= '0;
      r_mem_dout <= '0;
      r_wr       <= 1'b0;
      r_if_data  <= '0;
      r_lb_data  <= '0;
      r_if_done  <= 1'b0;
      r_lb_done  <= 1'b0;
      r_rob_done <= 1'b0;
    end else if (rdy_in) begin
      r_if_done  <= 1'b0;
      r_lb_done  <= 1'b0;
      r_rob_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_k <= '0;
          if (w_gnt_rob) begin
            r_owner    <= OWN_ROB;
            r_len      <= f_len(rob_width_in);
            r_wdat     <= rob_data_in;
            r_io       <= (rob_addr_in[17:16] == IO_SEL);
            r_mem_a    <= rob_addr_in;
            r_mem_dout <= rob_data_in[7:0];
            r_wr       <= 1'b1;
            r_state    <= S_WRITE;
          end else if (w_gnt_lb) begin
            r_owner <= OWN_LB;
            r_len   <= f_len(lb_width_in);
            r_buf   <= '0;
            r_io    <= 1'b0;
            r_mem_a <= lb_addr_in;
            r_state <= S_READ;
          end else if (w_gnt_if) begin
            r_owner <= OWN_IF;
            r_len   <= 3'd4;
            r_buf   <= '0;
            r_io    <= 1'b0;
            r_mem_a <= if_addr_in;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (rob_rst_in) begin
            r_state <= S_IDLE;
          end else begin
            if (r_k != 3'd0)
              r_buf <= w_rdata;
            if ((r_k + 3'd1) < r_len)
              r_mem_a <= r_mem_a + 1'b1;
            r_k <= r_k + 3'd1;
            // r_k == len means the last byte is on mem_din_in right now.
            if (r_k == r_len) begin
              r_state <= S_DONE;
              if (r_owner == OWN_IF) begin
                r_if_data <= w_rdata;
                r_if_done <= 1'b1;
              end else begin
                r_lb_data <= w_rdata;
                r_lb_done <= 1'b1;
              end
            end
          end
        end
        S_WRITE: begin
          if (!w_stall) begin
            if (r_k == r_len - 3'd1) begin
              r_wr       <= 1'b0;
              r_rob_done <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_k        <= r_k + 3'd1;
              r_mem_a    <= r_mem_a + 1'b1;
              r_mem_dout <= r_wdat[{w_nxt_idx, 3'b000} +: 8];
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_a_out    = r_mem_a;
  assign mem_dout_out = r_mem_dout;
  assign mem_wr_out   = r_wr && rdy_in && !w_stall;
  assign if_data_out  = r_if_data;
  assign if_done_out  = r_if_done;
  assign lb_data_out  = r_lb_data;
  assign lb_done_out  = r_lb_done;
  assign rob_done_out = r_rob_done;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for mem_arbiter: directed requests push expected results, a negedge monitor checks them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, rob_rst, io_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_en, lb_en, rob_en;
  logic [31:0] if_addr, lb_addr, rob_addr, rob_data;
  logic [2:0]  lb_width, rob_width;
  logic [31:0] if_data, lb_data;
  logic        if_done, lb_done, rob_done;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .IO_SEL(2'b11)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .rob_rst_in(rob_rst), .io_full_in(io_full),
    .mem_din_in(mem_din), .mem_dout_out(mem_dout), .mem_a_out(mem_a), .mem_wr_out(mem_wr),
    .if_en_in(if_en), .if_addr_in(if_addr), .if_data_out(if_data), .if_done_out(if_done),
    .lb_en_in(lb_en), .lb_addr_in(lb_addr), .lb_width_in(lb_width), .lb_data_out(lb_data),
    .lb_done_out(lb_done), .rob_en_in(rob_en), .rob_addr_in(rob_addr), .rob_width_in(rob_width),
    .rob_data_in(rob_data), .rob_done_out(rob_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] dat; int cyc; } rsp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; int cyc; } wr_t;

  rsp_t q_if[$], q_lb[$], q_rob[$];
  wr_t  q_wr[$];
  rsp_t m_r;
  wr_t  m_w;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0;
  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return 8'h00;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: one-cycle read latency, write on the clock edge.
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= rd(mem_a);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (if_done) begin
        if (q_if.size() == 0) chk("if_done_unexpected", 32'(if_done), 32'h0);
        else begin
          m_r = q_if.pop_front();
          chk("if_data", if_data, m_r.dat);
          chk("if_done_cycle", 32'(cyc), 32'(m_r.cyc));
        end
      end
      if (lb_done) begin
        if (q_lb.size() == 0) chk("lb_done_unexpected", 32'(lb_done), 32'h0);
        else begin
          m_r = q_lb.pop_front();
          chk("lb_data", lb_data, m_r.dat);
          chk("lb_done_cycle", 32'(cyc), 32'(m_r.cyc));
        end
      end
      if (rob_done) begin
        if (q_rob.size() == 0) chk("rob_done_unexpected", 32'(rob_done), 32'h0);
        else begin
          m_r = q_rob.pop_front();
          chk("rob_done_cycle", 32'(cyc), 32'(m_r.cyc));
        end
      end
      if (mem_wr) begin
        if (q_wr.size() == 0) chk("write_unexpected", 32'(mem_wr), 32'h0);
        else begin
          m_w = q_wr.pop_front();
          chk("wr_addr", mem_a, m_w.a);
          chk("wr_byte", 32'(mem_dout), 32'(m_w.d));
          chk("wr_cycle", 32'(cyc), 32'(m_w.cyc));
        end
      end
    end
  end

  task automatic exp_wr(input logic [31:0] a, input logic [7:0] d, input int c);
    q_wr.push_back('{a: a, d: d, cyc: c});
  endtask

  task automatic wait_done(input int which);
    logic seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      case (which)
        0:       seen = if_done;
        1:       seen = lb_done;
        default: seen = rob_done;
      endcase
    end
    if (!seen) chk("done_timeout", 32'(seen), 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic req_if(input logic [31:0] a, input logic [31:0] d, input int ec);
    q_if.push_back('{dat: d, cyc: ec});
    if_addr = a; if_en = 1'b1;
    wait_done(0);
    if_en = 1'b0;
  endtask

  task automatic req_lb(input logic [31:0] a, input logic [2:0] w, input logic [31:0] d, input int ec);
    q_lb.push_back('{dat: d, cyc: ec});
    lb_addr = a; lb_width = w; lb_en = 1'b1;
    wait_done(1);
    lb_en = 1'b0;
  endtask

  task automatic req_rob(input logic [31:0] a, input logic [2:0] w, input logic [31:0] d, input int ec);
    q_rob.push_back('{dat: 32'h0, cyc: ec});
    rob_addr = a; rob_width = w; rob_data = d; rob_en = 1'b1;
    wait_done(2);
    rob_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; rob_rst = 1'b0; io_full = 1'b0;
    if_en = 1'b0; lb_en = 1'b0; rob_en = 1'b0;
    if_addr = '0; lb_addr = '0; rob_addr = '0; rob_data = '0;
    lb_width = 3'b100; rob_width = 3'b100;
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h2002] = 8'hFE; ram[32'h2003] = 8'hFF;
    ram[32'h0000] = 8'hB7; ram[32'h0001] = 8'h40; ram[32'h0002] = 8'h01; ram[32'h0003] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_mem_dout", 32'(mem_dout), 32'h0);
    chk("rst_if_done", 32'(if_done), 32'h0);
    chk("rst_lb_done", 32'(lb_done), 32'h0);
    chk("rst_rob_done", 32'(rob_done), 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_lb_data", lb_data, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // IF word fetch
    t0 = cyc;
    req_if(32'h1000, 32'h0000_0513, t0 + 6);

    // LB half read, then SB
    t0 = cyc;
    req_lb(32'h2002, 3'b010, 32'h0000_FFFE, t0 + 4);
    t0 = cyc;
    exp_wr(32'h10, 8'hAB, t0 + 1);
    req_rob(32'h10, 3'b001, 32'h0000_00AB, t0 + 2);

    // All three requesters at once: ROB, then LB (reads back a stored byte), then IF
    t0 = cyc;
    exp_wr(32'h40, 8'hEF, t0 + 1);
    exp_wr(32'h41, 8'hBE, t0 + 2);
    exp_wr(32'h42, 8'hAD, t0 + 3);
    exp_wr(32'h43, 8'hDE, t0 + 4);
    fork
      req_rob(32'h40, 3'b100, 32'hDEAD_BEEF, t0 + 5);
      req_lb(32'h41, 3'b001, 32'h0000_00BE, t0 + 9);
      req_if(32'h1000, 32'h0000_0513, t0 + 16);
    join

    // Flush during an IF read
    t0 = cyc;
    if_addr = 32'h1004; if_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rob_rst = 1'b1; if_en = 1'b0;
    @(posedge clk); #1;
    rob_rst = 1'b0;
    chk("flush_if_data_kept", if_data, 32'h0000_0513);
    @(posedge clk); #1;
    t0 = cyc;
    req_if(32'h0, 32'h0001_40B7, t0 + 6);

    // SW into the IO window with io_full high in cycles 1-3
    t0 = cyc;
    exp_wr(32'h30000, 8'h44, t0 + 4);
    exp_wr(32'h30001, 8'h33, t0 + 5);
    exp_wr(32'h30002, 8'h22, t0 + 6);
    exp_wr(32'h30003, 8'h11, t0 + 7);
    fork
      req_rob(32'h30000, 3'b100, 32'h1122_3344, t0 + 8);
      begin
        @(posedge clk); #1;
        io_full = 1'b1;
        repeat (3) @(posedge clk);
        #1 io_full = 1'b0;
      end
    join

    // SW with a two-cycle freeze after the first byte
    t0 = cyc;
    exp_wr(32'h80, 8'h88, t0 + 1);
    exp_wr(32'h81, 8'h77, t0 + 4);
    exp_wr(32'h82, 8'h66, t0 + 5);
    exp_wr(32'h83, 8'h55, t0 + 6);
    fork
      req_rob(32'h80, 3'b100, 32'h5566_7788, t0 + 7);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rdy = 1'b1;
      end
    join

    // Asynchronous reset in the middle of an LB word read
    t0 = cyc;
    lb_addr = 32'h1000; lb_width = 3'b100; lb_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_mem_a", mem_a, 32'h0);
    chk("arst_mem_wr", 32'(mem_wr), 32'h0);
    chk("arst_mem_dout", 32'(mem_dout), 32'h0);
    chk("arst_lb_data", lb_data, 32'h0);
    chk("arst_if_data", if_data, 32'h0);
    chk("arst_lb_done", 32'(lb_done), 32'h0);
    lb_en = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    t0 = cyc;
    req_lb(32'h1000, 3'b001, 32'h0000_0013, t0 + 3);

    repeat (5) @(posedge clk);
    #1;
    chk("q_if_left", 32'(q_if.size()), 32'h0);
    chk("q_lb_left", 32'(q_lb.size()), 32'h0);
    chk("q_rob_left", 32'(q_rob.size()), 32'h0);
    chk("q_wr_left", 32'(q_wr.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
